// File: rtl/fibre_a_responder.sv
// fibre_a_responder: loadable spike-vector table served on a fixed-latency pipelined read port
module fibre_a_responder #(
  parameter int TIMESTEPS    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 128,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_count_i,
  input  logic [TIMESTEPS-1:0]  load_data_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  output logic                  load_done_o,
  output logic                  mem_ready_o,
  input  logic [ADDR_WIDTH-1:0] fibre_a_addr_i,
  input  logic                  fibre_a_read_en_i,
  output logic [TIMESTEPS-1:0]  fibre_a_data_o,
  output logic                  fibre_a_valid_o,
  output logic                  rd_err_o,
  output logic [15:0]           serve_count_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);
  localparam int L = READ_LATENCY;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] n_q, n_d, wptr_q, wptr_d, lcnt;
  logic [DEPTH-1:0] bmap_q, bmap_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, drop_q;
  logic start, beat, last, acc, oor;
  logic [IW-1:0] ra;
  logic [TIMESTEPS-1:0] rdata;
  logic [TIMESTEPS-1:0] mem [DEPTH];
  logic [L-1:0] pv_q, pe_q;
  logic [L*TIMESTEPS-1:0] pd_q;
  logic [L:0] sv, se;
  logic [(L+1)*TIMESTEPS-1:0] sd;
  assign start = load_start_i && state_q != LOAD;
  assign beat  = load_valid_i && state_q == LOAD;
  assign last  = beat && wptr_q + CW'(1) == n_q;
  assign lcnt  = {1'b0, load_count_i};
  assign acc   = fibre_a_read_en_i && state_q == SERVE;
  assign oor   = {1'b0, fibre_a_addr_i} >= DMAX;
  assign ra    = fibre_a_addr_i[IW-1:0];
  assign rdata = !oor && bmap_q[ra] ? mem[ra] : '0;
  // stage 0 is the accept-cycle lookup; the top stage drives the outputs
  assign sv = {pv_q, acc};
  assign se = {pe_q, oor};
  assign sd = {pd_q, rdata};
  assign load_ready_o    = state_q == LOAD;
  assign mem_ready_o     = state_q == SERVE;
  assign load_done_o     = done_q;
  assign fibre_a_valid_o = sv[L];
  assign fibre_a_data_o  = sd[L*TIMESTEPS +: TIMESTEPS];
  assign rd_err_o        = (sv[L] && se[L]) || drop_q;
  assign serve_count_o   = cnt_q;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    bmap_d  = bmap_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start) begin
      n_d    = lcnt > DMAX ? DMAX : lcnt;
      wptr_d = '0;
      bmap_d = '0;
      cnt_d  = '0;
      done_d = n_d == '0;
      if (n_d == '0) state_d = SERVE;
      else state_d = LOAD;
    end else begin
      cnt_d = fibre_a_valid_o && cnt_q != 16'hFFFF ? cnt_q + 16'd1 : cnt_q;
      if (beat) begin
        bmap_d[wptr_q[IW-1:0]] = 1'b1;
        wptr_d = wptr_q + CW'(1);
      end
      if (last) begin
        state_d = SERVE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      wptr_q  <= '0;
      bmap_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wptr_q  <= wptr_d;
      bmap_q  <= bmap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      drop_q  <= fibre_a_read_en_i && state_q != SERVE;
    end
  // table storage is not reset; the written-bitmap masks stale entries
  always_ff @(posedge clk)
    if (beat) mem[wptr_q[IW-1:0]] <= load_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv_q <= '0;
      pe_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= sv[L-1:0];
      pe_q <= se[L-1:0];
      for (int i = 0; i < L; i++)
        if (sv[i]) pd_q[i*TIMESTEPS +: TIMESTEPS] <= sd[i*TIMESTEPS +: TIMESTEPS];
    end
endmodule

// File: doc/fibre_a_responder.md
# fibre_a_responder

Responder end of the fibre A read interface used by the accumulator correction stage. The block holds the per-column spike vectors (one TIMESTEPS-bit word per offset) and serves them on a fixed-latency, fully pipelined read port. Before serving, a table is streamed in through a load port, and it can be reloaded between tiles. Entries not written since the last load read back as all-zeros.

## Interface
- TIMESTEPS, 8, width of one spike vector (bit t = spike at timestep t)
- ADDR_WIDTH, 8, width of read address and load count
- DEPTH, 128, number of table entries (≤ 2^ADDR_WIDTH)
- READ_LATENCY, 2, cycles from accepted read to fibre_a_valid (legal 1..4)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: begin a new table load
- load_count  in  ADDR_WIDTH  entries to load, sampled with load_start
- load_data  in  TIMESTEPS  spike vector beat
- load_valid  in  1  load_data valid
- load_ready  out  1  block accepts a load beat this cycle
- load_done  out  1  one-cycle pulse, last beat written
- mem_ready  out  1  table loaded, reads accepted
- fibre_a_addr  in  ADDR_WIDTH  read address (offset)
- fibre_a_read_en  in  1  read request, one per cycle max
- fibre_a_data  out  TIMESTEPS  read data
- fibre_a_valid  out  1  one-cycle pulse, fibre_a_data valid
- rd_err  out  1  one-cycle pulse, request dropped or out of range
- serve_count  out  16  reads served since last load_start, saturating

## Operation
- States: IDLE (after reset, nothing loaded), LOAD, SERVE.
- IDLE/SERVE + load_start: latch n = min(load_count, DEPTH), clear write pointer, clear the DEPTH-bit written-bitmap and serve_count in the same cycle, then go to LOAD. If n = 0, go straight to SERVE and pulse load_done.
- load_start while in LOAD is ignored.
- LOAD: load_ready = 1. Each load_valid && load_ready writes load_data at the write pointer, sets its bitmap bit, and increments the pointer. The beat that writes entry n-1 moves the block to SERVE; load_done pulses the next cycle.
- mem_ready = 1 exactly when the state is SERVE.
- A read is accepted when fibre_a_read_en && state == SERVE.
- Accepted read with addr < DEPTH: data is the stored word if its bitmap bit is set, else 0. This covers entries at or above n.
- Accepted read with addr ≥ DEPTH: data is 0, fibre_a_valid still pulses, rd_err pulses at the same time as fibre_a_valid.
- A request received outside SERVE is dropped: no fibre_a_valid, and rd_err pulses the next cycle.
- Array read and bitmap check happen in the accept cycle. The result passes through a valid/data shift pipeline of depth READ_LATENCY.
- In-flight reads therefore complete with pre-reload data even if load_start arrives while they are in flight.
- serve_count increments on every fibre_a_valid and saturates at 16'hFFFF.
- Reads and writes never overlap because reads are served only in SERVE and writes happen only in LOAD. No read/write collision rule is needed.

## Timing
- Reset values: load_ready 0, load_done 0, mem_ready 0, fibre_a_data 0, fibre_a_valid 0, rd_err 0, serve_count 0. State is IDLE, bitmap is cleared, pipeline valids are cleared. Array contents are not reset (the bitmap masks them).
- load_start at cycle T gives load_ready = 1 from T+1.
- Final beat at cycle W gives load_ready = 0, load_done = 1 and mem_ready = 1 at W+1. Reads are accepted from W+1.
- n = 0: load_done = 1 and mem_ready = 1 at T+1.
- Read accepted at cycle R: fibre_a_valid = 1 at R+READ_LATENCY. Throughput is one read per cycle with no back-pressure.
- fibre_a_data holds its last value between valid pulses.
- rst_n low mid-load or mid-read: immediate return to reset values. Pending reads are lost with no valid pulse, and a new load is required.

## Test plan
- Reset, load_start with load_count=4, beats 8'hFF, 8'h0F, 8'hA5, 8'h00 back-to-back -> load_done at the cycle after beat 4, mem_ready=1.
- After that load, read addrs 0,1,2,3 on consecutive cycles -> valid at R+2 each, data FF, 0F, A5, 00; serve_count=4.
- Read addr 10 (unwritten) -> data 00, rd_err 0. Read addr 200 -> data 00, valid 1, rd_err 1.
- Read while in IDLE and while in LOAD -> no fibre_a_valid, rd_err pulse one cycle later.
- Read addr 2 issued, then load_start next cycle with load_count=0 -> valid returns old A5; subsequent read addr 2 -> 00; mem_ready stays 1.
- load_count=255 -> clamped to 128 beats, load_done after the 128th. Assert rst_n low during beat 50 -> all outputs 0, mem_ready 0, state IDLE.
